// File: rtl/jk_excitation_ctrl_if.sv
// ---------------------------------------------------------------------------
// jk_excitation_ctrl_if : request handshake and JK bank signals | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface jk_excitation_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_target;
  logic             abort;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             err;
  logic [3:0]       retry_cnt;

  modport master (
    output req_valid, req_target, abort, q_fb,
    input  req_ready, j, k, busy, done, err, retry_cnt
  );

  modport slave (
    input  req_valid, req_target, abort, q_fb,
    output req_ready, j, k, busy, done, err, retry_cnt
  );
endinterface

`default_nettype wire

// File: rtl/jk_excitation_ctrl.sv
// ---------------------------------------------------------------------------
// jk_excitation_ctrl : drives J/K excitation into a JK bank, checks, retries | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module jk_excitation_ctrl #(
  parameter int WIDTH       = 8,
  parameter int MAX_RETRY   = 3,
  parameter int TOGGLE_MODE = 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  jk_excitation_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

  state_t           state_q;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] j_q;
  logic [WIDTH-1:0] k_q;
  logic             busy_q;
  logic             ready_q;
  logic             done_q;
  logic             err_q;
  logic [3:0]       retry_q;

  logic [WIDTH-1:0] exc_tgt_d;
  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic             match_d;

  // In IDLE the excitation targets the incoming request; otherwise the captured one.
  assign exc_tgt_d = (state_q == IDLE) ? bus.req_target : tgt_q;
  assign diff_d    = bus.q_fb ^ exc_tgt_d;
  assign match_d   = (diff_d == '0);

  generate
    if (TOGGLE_MODE != 0) begin : g_toggle
      assign j_d = diff_d;
      assign k_d = diff_d;
    end else begin : g_direct
      assign j_d = diff_d & exc_tgt_d;
      assign k_d = diff_d & ~exc_tgt_d;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      retry_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // busy in IDLE means a request already matched the bank on acceptance.
          if (busy_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else if (bus.req_valid) begin
            tgt_q   <= bus.req_target;
            retry_q <= 4'd0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            if (!match_d) begin
              j_q     <= j_d;
              k_q     <= k_d;
              state_q <= SETTLE;
            end
          end
        end
        SETTLE: begin
          j_q <= '0;
          k_q <= '0;
          if (bus.abort) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          j_q <= '0;
          k_q <= '0;
          if (bus.abort) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else if (match_d) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else if (retry_q < MAX_RETRY_C) begin
            retry_q <= retry_q + 4'd1;
            j_q     <= j_d;
            k_q     <= k_d;
            state_q <= SETTLE;
          end else begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          j_q     <= '0;
          k_q     <= '0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.busy      = busy_q;
  assign bus.req_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.retry_cnt = retry_q;

endmodule

`default_nettype wire

// File: tb/tb_jk_excitation_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jk_excitation_ctrl : directed vectors against a behavioural JK bank | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_jk_excitation_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic       valid;
  logic       abort;
  logic [7:0] target;
  logic       load0, load1;
  logic [7:0] load_val;
  logic [7:0] stuck0;
  logic [7:0] bq0, bq1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jk_excitation_ctrl_if #(.WIDTH(8)) if0 ();
  jk_excitation_ctrl_if #(.WIDTH(8)) if1 ();

  jk_excitation_ctrl #(.WIDTH(8), .MAX_RETRY(3), .TOGGLE_MODE(1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  jk_excitation_ctrl #(.WIDTH(8), .MAX_RETRY(3), .TOGGLE_MODE(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  assign if0.req_valid  = valid && !sel;
  assign if1.req_valid  = valid && sel;
  assign if0.req_target = target;
  assign if1.req_target = target;
  assign if0.abort      = abort && !sel;
  assign if1.abort      = abort && sel;
  assign if0.q_fb       = bq0;
  assign if1.q_fb       = bq1;

  function automatic logic [7:0] jk_next(input logic [7:0] q, input logic [7:0] j, input logic [7:0] k);
    return (j & ~q) | (~k & q);
  endfunction

  // Behavioural JK bank; stuck0 forces selected bits of bank 0 low.
  always @(posedge clk) begin
    if (load0) bq0 <= load_val;
    else       bq0 <= jk_next(bq0, if0.j, if0.k) & ~stuck0;
    if (load1) bq1 <= load_val;
    else       bq1 <= jk_next(bq1, if1.j, if1.k);
  end

  logic [7:0] s_j, s_k;
  logic       s_done, s_err, s_busy, s_ready;
  logic [3:0] s_retry;
  assign s_j     = sel ? if1.j         : if0.j;
  assign s_k     = sel ? if1.k         : if0.k;
  assign s_done  = sel ? if1.done      : if0.done;
  assign s_err   = sel ? if1.err       : if0.err;
  assign s_busy  = sel ? if1.busy      : if0.busy;
  assign s_ready = sel ? if1.req_ready : if0.req_ready;
  assign s_retry = sel ? if1.retry_cnt : if0.retry_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_bank(input logic inst, input logic [7:0] v);
    load_val = v;
    if (inst) load1 = 1'b1; else load0 = 1'b1;
    @(posedge clk); #1;
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  // Issues one request (valid held while busy) and observes 20 cycles after acceptance.
  task automatic run_req(input logic [7:0] tgt, input int abort_at,
                         output int done_cyc, output int err_cyc, output int dones, output int errs,
                         output int pulses, output int held, output int both,
                         output logic [7:0] fj, output logic [7:0] fk,
                         output logic rdy_end, output logic [3:0] rcnt_end);
    bit prev = 0;
    done_cyc = -1; err_cyc = -1; dones = 0; errs = 0;
    pulses = 0; held = 0; both = 0;
    fj = 8'hxx; fk = 8'hxx; rdy_end = 1'b0; rcnt_end = 4'hx;
    valid  = 1'b1;
    target = tgt;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      abort = 1'b0;
      if (c == 0) begin fj = s_j; fk = s_k; end
      if (s_j != 8'h00 || s_k != 8'h00) begin
        pulses++;
        if (prev) held++;
        prev = 1;
      end else begin
        prev = 0;
      end
      if (s_done) begin dones++; if (done_cyc < 0) done_cyc = c; end
      if (s_err)  begin errs++;  if (err_cyc < 0)  err_cyc = c;  end
      if (s_done && s_err) both++;
      if (s_done || s_err) begin
        valid    = 1'b0;
        rdy_end  = s_ready;
        rcnt_end = s_retry;
      end
      if (c == abort_at) abort = 1'b1;
    end
    valid = 1'b0;
  endtask

  typedef struct {
    logic       inst;
    logic [7:0] q0;
    logic [7:0] tgt;
    logic [7:0] ej;
    logic [7:0] ek;
    int         lat;
  } vec_t;

  vec_t vecs [6];

  int         done_cyc, err_cyc, dones, errs, pulses, held, both;
  logic [7:0] fj, fk;
  logic       rdy_end;
  logic [3:0] rcnt_end;
  int         late_ev;

  initial begin
    vecs[0] = '{1'b0, 8'h00, 8'hA5, 8'hA5, 8'hA5, 2};
    vecs[1] = '{1'b0, 8'h3C, 8'h3C, 8'h00, 8'h00, 1};
    vecs[2] = '{1'b0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 2};
    vecs[3] = '{1'b0, 8'h0F, 8'h3C, 8'h33, 8'h33, 2};
    vecs[4] = '{1'b1, 8'hF0, 8'h0F, 8'h0F, 8'hF0, 2};
    vecs[5] = '{1'b1, 8'h55, 8'h5C, 8'h08, 8'h01, 2};

    reset = 1'b0; sel = 1'b0; valid = 1'b0; abort = 1'b0; target = 8'h00;
    load0 = 1'b0; load1 = 1'b0; load_val = 8'h00; stuck0 = 8'h00;

    #12;
    chk("rst_j0",     {24'h0, if0.j},      32'h0);
    chk("rst_k0",     {24'h0, if0.k},      32'h0);
    chk("rst_ready0", {31'h0, if0.req_ready}, 32'h1);
    chk("rst_busy0",  {31'h0, if0.busy},   32'h0);
    chk("rst_done0",  {31'h0, if0.done},   32'h0);
    chk("rst_err0",   {31'h0, if0.err},    32'h0);
    chk("rst_retry0", {28'h0, if0.retry_cnt}, 32'h0);
    chk("rst_ready1", {31'h0, if1.req_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      sel = vecs[v].inst;
      load_bank(vecs[v].inst, vecs[v].q0);
      run_req(vecs[v].tgt, -1, done_cyc, err_cyc, dones, errs, pulses, held, both,
              fj, fk, rdy_end, rcnt_end);
      chk($sformatf("v%0d_j", v),       {24'h0, fj},       {24'h0, vecs[v].ej});
      chk($sformatf("v%0d_k", v),       {24'h0, fk},       {24'h0, vecs[v].ek});
      chk($sformatf("v%0d_lat", v),     done_cyc,          vecs[v].lat);
      chk($sformatf("v%0d_dones", v),   dones,             1);
      chk($sformatf("v%0d_errs", v),    errs,              0);
      chk($sformatf("v%0d_pulses", v),  pulses,            (vecs[v].lat == 2) ? 1 : 0);
      chk($sformatf("v%0d_held", v),    held,              0);
      chk($sformatf("v%0d_retry", v),   {28'h0, rcnt_end}, 32'h0);
      chk($sformatf("v%0d_ready", v),   {31'h0, rdy_end},  32'h1);
    end

    // Bit 0 stuck low: four drive attempts then an error.
    sel = 1'b0;
    stuck0 = 8'h01;
    load_bank(1'b0, 8'h00);
    run_req(8'h01, -1, done_cyc, err_cyc, dones, errs, pulses, held, both,
            fj, fk, rdy_end, rcnt_end);
    chk("stuck_j",      {24'h0, fj}, 32'h01);
    chk("stuck_k",      {24'h0, fk}, 32'h01);
    chk("stuck_pulses", pulses,      4);
    chk("stuck_held",   held,        0);
    chk("stuck_errcyc", err_cyc,     8);
    chk("stuck_errs",   errs,        1);
    chk("stuck_dones",  dones,       0);
    chk("stuck_retry",  {28'h0, rcnt_end}, 32'h3);
    chk("stuck_both",   both,        0);

    // Abort during CHECK while the bank still mismatches.
    stuck0 = 8'hFF;
    load_bank(1'b0, 8'h00);
    run_req(8'hFF, 1, done_cyc, err_cyc, dones, errs, pulses, held, both,
            fj, fk, rdy_end, rcnt_end);
    chk("abort_j",      {24'h0, fj}, 32'hFF);
    chk("abort_errcyc", err_cyc,     2);
    chk("abort_errs",   errs,        1);
    chk("abort_dones",  dones,       0);
    chk("abort_pulses", pulses,      1);
    chk("abort_retry",  {28'h0, rcnt_end}, 32'h0);
    chk("abort_ready",  {31'h0, rdy_end},  32'h1);
    stuck0 = 8'h00;

    // Asynchronous reset in the middle of SETTLE.
    load_bank(1'b0, 8'h00);
    valid  = 1'b1;
    target = 8'h55;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("mid_j_before", {24'h0, if0.j}, 32'h55);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_j",     {24'h0, if0.j},         32'h0);
    chk("mid_k",     {24'h0, if0.k},         32'h0);
    chk("mid_busy",  {31'h0, if0.busy},      32'h0);
    chk("mid_ready", {31'h0, if0.req_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    late_ev = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (if0.done || if0.err || if0.j != 8'h00 || if0.busy) late_ev++;
    end
    chk("mid_no_events", late_ev, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
